// File: rtl/alu_mul_sequencer.sv
// Shift-add multiply sequencer that borrows the shared ALU adder, one
// partial product per cycle, and returns the low WIDTH bits of A*B.
module alu_mul_sequencer #(
  parameter int WIDTH = 64,
  parameter int CNT_W = 7
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [WIDTH-1:0] multiplicand,
  input  logic [WIDTH-1:0] multiplier,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] product,
  output logic [WIDTH-1:0] alu_a,
  output logic [WIDTH-1:0] alu_b,
  output logic [3:0]       alu_op,
  input  logic [WIDTH-1:0] alu_result
);

  // state | meaning
  // IDLE  | waiting for start, ALU operands parked at zero
  // CALC  | one shift-add iteration per cycle through the ALU
  // DONE  | product valid, done pulses; start here chains straight to CALC
  typedef enum logic [1:0] {IDLE = 2'd0, CALC = 2'd1, DONE = 2'd2} state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] acc, mcand, mplr;
  logic [CNT_W-1:0] count;
  logic             load, last;

  assign busy   = (state_q == CALC);
  assign done   = (state_q == DONE);
  assign alu_op = 4'b0010;

  always_comb begin
    state_d = state_q;
    load    = 1'b0;
    last    = 1'b0;
    alu_a   = '0;
    alu_b   = '0;
    case (state_q)
      IDLE: begin
        if (start) begin
          state_d = CALC;
          load    = 1'b1;
        end
      end
      CALC: begin
        alu_a = acc;
        alu_b = mplr[0] ? mcand : '0;
        // Stop as soon as no multiplier bits remain, so K tracks the top set bit.
        last  = (mplr[WIDTH-1:1] == '0) || (count == CNT_W'(WIDTH - 1));
        if (last) state_d = DONE;
      end
      DONE: begin
        if (start) begin
          state_d = CALC;
          load    = 1'b1;
        end else begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      acc     <= '0;
      mcand   <= '0;
      mplr    <= '0;
      count   <= '0;
      product <= '0;
    end else begin
      state_q <= state_d;
      if (load) begin
        acc     <= '0;
        mcand   <= multiplicand;
        mplr    <= multiplier;
        count   <= '0;
        product <= '0;
      end else if (state_q == CALC) begin
        acc   <= alu_result;
        mcand <= mcand << 1;
        mplr  <= mplr >> 1;
        count <= count + CNT_W'(1);
        if (last) product <= alu_result;
      end
    end
  end

endmodule
